// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter with lock-based ownership and a one-cycle read return path.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default build is fixed priority to port 0.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r0_lock,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_lock,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   last_gnt_r;
  logic   pend0_r;
  logic   pend1_r;
  logic   gnt0_s;
  logic   gnt1_s;
  logic   pick1_s;

`ifdef MEM_ARB_RR_EN
  // On a tie, favour the port that was not served last.
  assign pick1_s = ~last_gnt_r;
`else
  // Fixed priority to port 0; last_gnt_r is still tracked but does not steer the tie.
  assign pick1_s = 1'b0 & last_gnt_r;
`endif

  // Next-state and grant decode.
  always_comb begin
    state_nxt_s = IDLE;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (r0_req && r1_req) begin
          if (pick1_s) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end else if (r0_req) begin
          gnt0_s = 1'b1;
        end else if (r1_req) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
        end
      end
      OWN0: begin
        if (r0_req) begin
          gnt0_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
        end
      end
      OWN1: begin
        if (r1_req) begin
          gnt1_s = 1'b1;
        end else begin
          gnt1_s = 1'b0;
        end
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
    if (gnt0_s) begin
      state_nxt_s = r0_lock ? OWN0 : IDLE;
    end else if (gnt1_s) begin
      state_nxt_s = r1_lock ? OWN1 : IDLE;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Grants are combinational, so reset must gate them directly to hold them low.
  assign r0_gnt = gnt0_s & rst_n;
  assign r1_gnt = gnt1_s & rst_n;

  // Memory command mux from the granted port.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = {ADDR_WIDTH{1'b0}};
    mem_data = {DATA_WIDTH{1'b0}};
    if (r0_gnt) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_data = r0_wdata;
    end else if (r1_gnt) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_data = r1_wdata;
    end else begin
      mem_we   = 1'b0;
    end
  end

  // State, last-granted port and pending-read flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      pend0_r    <= 1'b0;
      pend1_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pend0_r <= gnt0_s & ~r0_we;
      pend1_r <= gnt1_s & ~r1_we;
      if (gnt0_s) begin
        last_gnt_r <= 1'b0;
      end else if (gnt1_s) begin
        last_gnt_r <= 1'b1;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

  // Memory returns data one cycle after the address; pass it only to the port that read.
  assign r0_rvalid = pend0_r;
  assign r1_rvalid = pend1_r;
  assign r0_rdata  = pend0_r ? mem_in : {DATA_WIDTH{1'b0}};
  assign r1_rdata  = pend1_r ? mem_in : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
// Expected tie-break order follows MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_lock, r0_we, r1_req, r1_lock, r1_we;
  logic [5:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata, mem_in;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_we;
  logic [15:0] r0_rdata, r1_rdata, mem_data;
  logic [5:0]  mem_addr;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        rv0;
    logic        rv1;
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic        mwe;
    logic [5:0]  maddr;
    logic [15:0] mdata;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_lock(r0_lock), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_lock(r1_lock), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
  );

  always #5 clk = ~clk;

  function automatic obs_t snap();
    obs_t o;
    o.g0 = r0_gnt;  o.g1 = r1_gnt;  o.rv0 = r0_rvalid; o.rv1 = r1_rvalid;
    o.rd0 = r0_rdata; o.rd1 = r1_rdata; o.mwe = mem_we; o.maddr = mem_addr; o.mdata = mem_data;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got gnt=%b%b rv=%b%b rd0=%h rd1=%h we=%b addr=%h data=%h, want gnt=%b%b rv=%b%b rd0=%h rd1=%h we=%b addr=%h data=%h",
               nm, act.g0, act.g1, act.rv0, act.rv1, act.rd0, act.rd1, act.mwe, act.maddr, act.mdata,
               exp.g0, exp.g1, exp.rv0, exp.rv1, exp.rd0, exp.rd1, exp.mwe, exp.maddr, exp.mdata);
    end
  endtask

  function automatic obs_t mk(input logic g0, input logic g1, input logic rv0, input logic rv1,
                              input logic [15:0] rd0, input logic [15:0] rd1, input logic mwe,
                              input logic [5:0] maddr, input logic [15:0] mdata);
    obs_t o;
    o.g0 = g0; o.g1 = g1; o.rv0 = rv0; o.rv1 = rv1; o.rd0 = rd0; o.rd1 = rd1;
    o.mwe = mwe; o.maddr = maddr; o.mdata = mdata;
    return o;
  endfunction

  task automatic push(input string nm, input obs_t v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    exp_q.push_back(e);
  endtask

  task automatic drv(input logic q0, input logic l0, input logic w0, input logic [5:0] a0, input logic [15:0] d0,
                     input logic q1, input logic l1, input logic w1, input logic [5:0] a1, input logic [15:0] d1,
                     input logic [15:0] mi);
    r0_req = q0; r0_lock = l0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_lock = l1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    mem_in = mi;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.nm, snap(), e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_port;
  obs_t       zero_o;

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_port = 4'b1010;
`else
    exp_port = 4'b0000;
`endif
    zero_o = mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 6'h00, 16'h0);

    rst_n = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 6'h08, 16'h0, 1'b1, 1'b0, 1'b1, 6'h09, 16'hFFFF, 16'hAAAA);
    @(negedge clk);
    #1;
    check("reset_hold", snap(), zero_o);

    cyc(); rst_n = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("idle_after_reset", zero_o);

    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h08, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("r0_read_gnt", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 6'h08, 16'h0));
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h7123);
    push("r0_rvalid", mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h7123, 16'h0, 1'b0, 6'h00, 16'h0));

    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b1, 1'b0, 1'b1, 6'h3F, 16'hBEEF, 16'h0);
    push("r1_write_gnt", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'h3F, 16'hBEEF));
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h5555);
    push("write_no_rvalid", zero_o);

    // Both ports read continuously for four cycles; rvalid trails the grant by one cycle.
    for (int k = 0; k < 4; k++) begin
      logic p;
      logic pp;
      p  = exp_port[k];
      pp = (k > 0) ? exp_port[k-1] : 1'b0;
      cyc(); drv(1'b1, 1'b0, 1'b0, 6'h01, 16'h0, 1'b1, 1'b0, 1'b0, 6'h02, 16'h0, 16'h1000 + 16'(k));
      push($sformatf("tie_%0d", k),
           mk(~p, p, (k > 0) && !pp, (k > 0) && pp,
              ((k > 0) && !pp) ? 16'h1000 + 16'(k) : 16'h0,
              ((k > 0) && pp) ? 16'h1000 + 16'(k) : 16'h0,
              1'b0, p ? 6'h02 : 6'h01, 16'h0));
    end
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h1004);
    push("tie_tail_rvalid", mk(~exp_port[3], exp_port[3] & 1'b0, ~exp_port[3], exp_port[3],
                               exp_port[3] ? 16'h0 : 16'h1004, exp_port[3] ? 16'h1004 : 16'h0,
                               1'b0, 6'h00, 16'h0) & ~(obs_t'(1) << ($bits(obs_t) - 1)));

    // Port 1 takes and keeps ownership for three locked writes while port 0 waits.
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b1, 1'b1, 1'b1, 6'h10, 16'hA0A0, 16'h0);
    push("lock_1", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'h10, 16'hA0A0));
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h20, 16'h0, 1'b1, 1'b1, 1'b1, 6'h11, 16'hA1A1, 16'h0);
    push("lock_2", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'h11, 16'hA1A1));
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h20, 16'h0, 1'b1, 1'b1, 1'b1, 6'h12, 16'hA2A2, 16'h0);
    push("lock_3", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 6'h12, 16'hA2A2));
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h20, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("own1_release_idle", zero_o);
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h20, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("r0_after_lock", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 6'h20, 16'h0));
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h2468);
    push("r0_after_lock_rvalid", mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h2468, 16'h0, 1'b0, 6'h00, 16'h0));

    // Reset lands in the middle of a cycle that carries an r0 read grant.
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h08, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("pre_reset_gnt", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 6'h08, 16'h0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_zero", snap(), zero_o);
    cyc(); drv(1'b1, 1'b0, 1'b0, 6'h05, 16'h0, 1'b1, 1'b0, 1'b0, 6'h06, 16'h0, 16'h9999);
    push("reset_no_rvalid", zero_o);
    cyc(); rst_n = 1'b1;
    push("post_reset_first_p0", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 6'h05, 16'h0));
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h3333);
    push("post_reset_rvalid", mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 16'h0, 1'b0, 6'h00, 16'h0));
    cyc(); drv(1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 1'b0, 1'b0, 1'b0, 6'h00, 16'h0, 16'h0);
    push("final_idle", zero_o);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      passes++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports rN_req, input, 1, access request, N=0 (CPU) and N=1 (loader/debug).
REQ-006 SHALL have ports rN_lock, input, 1, keep ownership after this access.
REQ-007 SHALL have ports rN_we, input, 1, write enable; 0 = read.
REQ-008 SHALL have ports rN_addr, input, ADDR_WIDTH, access address.
REQ-009 SHALL have ports rN_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have ports rN_gnt, output, 1, access accepted this cycle.
REQ-011 SHALL have ports rN_rvalid, output, 1, read data valid.
REQ-012 SHALL have ports rN_rdata, output, DATA_WIDTH, read data.
REQ-013 SHALL have port mem_we, output, 1, memory write enable.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, memory address.
REQ-015 SHALL have port mem_data, output, DATA_WIDTH, memory write data.
REQ-016 SHALL have port mem_in, input, DATA_WIDTH, memory read data, one cycle after address.

Function
REQ-017 SHALL be an FSM with states IDLE, OWN0, OWN1; OWNn = port n locked the memory last cycle.
REQ-018 SHALL in IDLE, with one requester active, grant it combinationally in the same cycle.
REQ-019 SHALL in IDLE, with both active, grant by the arbitration policy in REQ-031/REQ-032.
REQ-020 SHALL in OWNn grant only port n.
REQ-021 SHALL in OWNn return to IDLE when rn_req=0, without granting anyone that cycle.
REQ-022 SHALL go to OWNn after a granted cycle with rN_lock=1; otherwise go to IDLE.
REQ-023 SHALL assert at most one rN_gnt per cycle.
REQ-024 SHALL drive mem_we/mem_addr/mem_data from the granted port; with no grant drive all zero (mem_we=0).
REQ-025 SHALL register a granted read; assert rN_rvalid on the next cycle only, with rN_rdata = mem_in.
REQ-026 SHALL hold rN_rdata at zero while rN_rvalid=0.
REQ-027 SHALL sustain back-to-back reads: one grant per cycle, rvalid stream one cycle behind.
REQ-028 SHALL generate no rvalid for writes.
REQ-029 SHALL let a requester without grant keep req and payload stable until granted.
- Requester behaviour is a protocol rule, not checked.
REQ-030 SHALL update last_gnt (1 bit, last granted port) on every grant.

Configuration
REQ-031 SHALL with MEM_ARB_RR_EN defined, on simultaneous requests in IDLE, grant the port not equal to last_gnt (round-robin).
REQ-032 SHALL with MEM_ARB_RR_EN undefined, on simultaneous requests in IDLE, always grant port 0 (fixed priority); last_gnt is still maintained.

Reset
REQ-033 SHALL on rst_n=0 immediately force: state IDLE, last_gnt=1, pending read flags clear.
REQ-034 SHALL hold during reset: all rN_gnt, rN_rvalid, rN_rdata and mem_* outputs = 0.
REQ-035 SHALL discard a read granted in the cycle reset asserts; no rvalid after reset release.
REQ-036 SHALL grant port 0 first on a post-reset simultaneous request in both configurations.

Verification
REQ-037 SHALL cover: r0 read addr 0x08, mem_in=0x7123 -> r0_gnt same cycle, mem_addr=0x08, mem_we=0, next cycle r0_rvalid=1 and r0_rdata=0x7123.
REQ-038 SHALL cover: r1 write addr 0x3F data 0xBEEF, r0 idle -> r1_gnt=1, mem_we=1, mem_addr=0x3F, mem_data=0xBEEF, no rvalid.
REQ-039 SHALL cover: both request for 4 cycles -> RR_EN: grants 0,1,0,1; without it: 0,0,0,0.
REQ-040 SHALL cover: r1 lock=1 for 3 accesses while r0 requests -> r1 granted 3 cycles, then r1_req=0 gives one idle cycle, then r0 granted.
REQ-041 SHALL cover: rst_n low in the same cycle as an r0 read grant -> all outputs 0 at once, no r0_rvalid after release, first post-reset grant to port 0.
